purify_nbr_filter: RTL

- Parametrised isolated-pixel removal filter for the camera pixel stream, placed between the pixel source and the downstream display/processing path.
- Holds its own two line buffers and a 3x3 window. It suppresses any centre pixel whose count of "on" neighbours is below a run-time minimum.
- Adds a threshold, a neighbour-count rule, a bypass, frame-aware edge masking and a valid-qualified output over the previous fixed all-zero-neighbour rule.

---
 rtl/purify_nbr_filter_if.sv | 36 +++
 rtl/purify_nbr_filter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/purify_nbr_filter_if.sv
// ----------------------------------------------------------------------------
// purify_nbr_filter_if
//
// Pixel stream bundle for the isolated-pixel removal filter. It carries the
// incoming frame/pixel stream and the filtered output stream.
//
// Signals:
//   iFVAL  frame valid (low between frames)
//   iDVAL  pixel valid, qualifies idata
//   idata  input pixel  [DATA_W-1:0]
//   odata  filtered pixel [DATA_W-1:0]
//   oDVAL  output valid
//
// Modports:
//   master  pixel source side: drives the input stream, observes the output
//   slave   filter side: receives the input stream, drives the output
// ----------------------------------------------------------------------------
interface purify_nbr_filter_if #(
    parameter int DATA_W = 10
);
    logic              iFVAL;
    logic              iDVAL;
    logic [DATA_W-1:0] idata;
    logic [DATA_W-1:0] odata;
    logic              oDVAL;

    modport master (
        output iFVAL, iDVAL, idata,
        input  odata, oDVAL
    );

    modport slave (
        input  iFVAL, iDVAL, idata,
        output odata, oDVAL
    );
endinterface

// File: rtl/purify_nbr_filter.sv
// ----------------------------------------------------------------------------
// purify_nbr_filter
//
// Isolated-pixel removal filter for a camera pixel stream. Two internal line
// buffers feed a 3x3 window; the window centre is suppressed to 0 when it is
// "on" (value > iTHRESH) and fewer than iMIN_NB of its 8 neighbours are on.
// The output is the centre pixel (row r-1, column c-1 relative to the current
// input), qualified by oDVAL exactly two clocks after each accepted pixel.
//
// Ports:
//   iCLK          pixel clock
//   iRST_N        asynchronous active-low reset
//   bus           purify_nbr_filter_if.slave (iFVAL, iDVAL, idata, odata, oDVAL)
//   iTHRESH       on-threshold, unsigned
//   iMIN_NB       minimum on-neighbours for an on centre to survive
//   iBYPASS       1 = always pass the centre pixel unchanged
//   oREMOVED_CNT  removed-pixel count of the last frame (PURIFY_STATS_EN only)
//
// Optional feature macro: PURIFY_STATS_EN adds the saturating removed-pixel
// counter, latched to oREMOVED_CNT on each iFVAL falling edge.
// ----------------------------------------------------------------------------
module purify_nbr_filter #(
    parameter int DATA_W = 10,
    parameter int LINE_W = 640,
    parameter int COL_W  = 10,
    parameter int CNT_W  = 20
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    purify_nbr_filter_if.slave  bus,
    input  logic [DATA_W-1:0]   iTHRESH,
    input  logic [3:0]          iMIN_NB,
    input  logic                iBYPASS
`ifdef PURIFY_STATS_EN
    ,
    output logic [CNT_W-1:0]    oREMOVED_CNT
`endif
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);

    logic                   acc;
    logic [COL_W-1:0]       col;
    logic [1:0]             row_cnt;

    logic [DATA_W-1:0]      lb0 [LINE_W];
    logic [DATA_W-1:0]      lb1 [LINE_W];
    logic [DATA_W-1:0]      lb0_rd, lb1_rd;
    logic [DATA_W-1:0]      lb0_m, lb1_m;

    // Index 2 is the newest column (c), 1 is c-1, 0 is c-2.
    logic [2:0][DATA_W-1:0] win_top;   // row r-2
    logic [2:0][DATA_W-1:0] win_mid;   // row r-1
    logic [2:0][DATA_W-1:0] win_bot;   // row r

    logic                   v1;
    logic [DATA_W-1:0]      centre;
    logic [7:0]             nb_on;
    logic [3:0]             nb_cnt;
    logic                   remove;

    assign acc = bus.iDVAL & bus.iFVAL;

    // Column / row position within the frame; row_cnt only needs to know
    // whether zero, one or two full lines have been stored.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            col     <= '0;
            row_cnt <= '0;
        end else if (!bus.iFVAL) begin
            col     <= '0;
            row_cnt <= '0;
        end else if (acc) begin
            if (col == COL_LAST) begin
                col <= '0;
                if (row_cnt != 2'd2)
                    row_cnt <= row_cnt + 2'd1;
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Asynchronous read gives read-before-write at the shared address: the
    // read sees last line's pixel while this line's pixel is written.
    assign lb0_rd = lb0[col];
    assign lb1_rd = lb1[col];

    always_ff @(posedge iCLK) begin
        if (acc) begin
            lb0[col] <= bus.idata;
            lb1[col] <= lb0_rd;
        end
    end

    // RAM contents are never cleared, so lines not yet written in this frame
    // are hidden here.
    assign lb0_m = (row_cnt != 2'd0) ? lb0_rd : '0;
    assign lb1_m = (row_cnt == 2'd2) ? lb1_rd : '0;

    // Window shift. At col 0 the older columns belong to the previous line,
    // so they are replaced by zeros instead of shifting in.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            win_top <= '0;
            win_mid <= '0;
            win_bot <= '0;
        end else if (!bus.iFVAL) begin
            win_top <= '0;
            win_mid <= '0;
            win_bot <= '0;
        end else if (acc) begin
            if (col == '0) begin
                win_top <= {lb1_m,     {DATA_W{1'b0}}, {DATA_W{1'b0}}};
                win_mid <= {lb0_m,     {DATA_W{1'b0}}, {DATA_W{1'b0}}};
                win_bot <= {bus.idata, {DATA_W{1'b0}}, {DATA_W{1'b0}}};
            end else begin
                win_top <= {lb1_m,     win_top[2], win_top[1]};
                win_mid <= {lb0_m,     win_mid[2], win_mid[1]};
                win_bot <= {bus.idata, win_bot[2], win_bot[1]};
            end
        end
    end

    // Valid for the decision stage; deliberately not cleared by iFVAL so that
    // pixels already in flight still emerge.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            v1 <= 1'b0;
        else
            v1 <= acc;
    end

    assign centre = win_mid[1];
    assign nb_on  = {win_top[0] > iTHRESH, win_top[1] > iTHRESH,
                     win_top[2] > iTHRESH, win_mid[0] > iTHRESH,
                     win_mid[2] > iTHRESH, win_bot[0] > iTHRESH,
                     win_bot[1] > iTHRESH, win_bot[2] > iTHRESH};

    always_comb begin
        nb_cnt = '0;
        for (int i = 0; i < 8; i++)
            nb_cnt = nb_cnt + {3'b000, nb_on[i]};
    end

    assign remove = !iBYPASS && (centre > iTHRESH) && (nb_cnt < iMIN_NB);

    // odata only updates with a valid decision and holds otherwise.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bus.odata <= '0;
            bus.oDVAL <= 1'b0;
        end else begin
            bus.oDVAL <= v1;
            if (v1)
                bus.odata <= remove ? '0 : centre;
        end
    end

`ifdef PURIFY_STATS_EN
    logic             fval_d;
    logic             rm_ev;
    logic [CNT_W-1:0] rm_cnt;
    logic [CNT_W-1:0] rm_next;

    assign rm_ev   = v1 & remove;
    assign rm_next = (rm_ev && (rm_cnt != '1)) ? rm_cnt + CNT_W'(1) : rm_cnt;

    // rm_next already folds in a removal landing on the falling-edge cycle.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            fval_d       <= 1'b0;
            rm_cnt       <= '0;
            oREMOVED_CNT <= '0;
        end else begin
            fval_d <= bus.iFVAL;
            if (fval_d && !bus.iFVAL) begin
                oREMOVED_CNT <= rm_next;
                rm_cnt       <= '0;
            end else begin
                rm_cnt <= rm_next;
            end
        end
    end
`endif

endmodule
